// File: rtl/router_tx_pkg.sv
// Shared types and constants for the router packet transmitter.
// Header layout: reserved bit above the 2-bit destination.
package router_tx_pkg;

  localparam int DATA_W = 3;
  localparam int LEN_W  = 4;

  localparam logic       HDR_RSVD     = 1'b0;
  localparam logic [1:0] DEST_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_ERRWAIT
  } state_t;

  function automatic logic [DATA_W-1:0] make_header(
    input logic [1:0] dest
  );
    return DATA_W'({HDR_RSVD, dest});
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Upstream command/payload and router ingress signals.
// master = source + router side, slave = transmitter.
interface router_pkt_tx_if #(
  parameter int DATA_W = 3,
  parameter int LEN_W  = 4
);

  logic              start;
  logic [1:0]        dest;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              busy;
  logic              err;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_out;
  logic              tx_active;
  logic              cmd_rej;
  logic              done;
  logic              pkt_err;

  modport master (
    output start, dest, len, src_data, src_valid,
    output busy, err,
    input  src_ready, pkt_valid, data_out,
    input  tx_active, cmd_rej, done, pkt_err
  );

  modport slave (
    input  start, dest, len, src_data, src_valid,
    input  busy, err,
    output src_ready, pkt_valid, data_out,
    output tx_active, cmd_rej, done, pkt_err
  );

endinterface

// File: rtl/router_tx_buf.sv
// Payload store: synchronous write, asynchronous read.
// Contents are not reset; every packet rewrites what it reads.
module router_tx_buf #(
  parameter int DATA_W = 3,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**LEN_W];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers a whole payload, then sends header, payload and
// parity to the router and reports the sampled err status.
module router_pkt_tx #(
  parameter int DATA_W   = router_tx_pkg::DATA_W,
  parameter int LEN_W    = router_tx_pkg::LEN_W,
  parameter int ERR_WAIT = 2
) (
  input  logic clock,
  input  logic reset,
  router_pkt_tx_if.slave bus
);

  import router_tx_pkg::*;

  localparam int TW = $clog2(ERR_WAIT + 1);

  state_t            state, state_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic [LEN_W-1:0]  idx, idx_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [1:0]        dest_q, dest_n;
  logic [DATA_W-1:0] par, par_n;
  logic [TW-1:0]     timer, timer_n;
  logic              eacc, eacc_n;

  logic              src_ready_q, pkt_valid_q;
  logic              pkt_valid_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              tx_active_q, cmd_rej_q;
  logic              cmd_rej_n;
  logic              done_q, done_n;
  logic              pkt_err_q, pkt_err_n;

  logic              we;
  logic [LEN_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hdr;
  logic              xfer;

  router_tx_buf #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_buf (
    .clock   (clock),
    .we      (we),
    .wr_addr (cnt),
    .wr_data (bus.src_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign hdr  = DATA_W'(make_header(dest_q));
  assign xfer = !bus.busy;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    len_n       = len_q;
    dest_n      = dest_q;
    par_n       = par;
    timer_n     = timer;
    eacc_n      = eacc;
    pkt_valid_n = pkt_valid_q;
    data_n      = data_q;
    cmd_rej_n   = 1'b0;
    done_n      = 1'b0;
    pkt_err_n   = pkt_err_q;
    we          = 1'b0;
    rd_addr     = (state == S_HEADER) ? '0 : idx;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.dest == DEST_ILLEGAL || bus.len == '0) begin
            cmd_rej_n = 1'b1;
          end else begin
            dest_n  = bus.dest;
            len_n   = bus.len;
            cnt_n   = '0;
            par_n   = '0;
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.src_valid && src_ready_q) begin
          we    = 1'b1;
          par_n = par ^ bus.src_data;
          cnt_n = cnt + LEN_W'(1);
          if (cnt == len_q - LEN_W'(1)) begin
            state_n     = S_HEADER;
            pkt_valid_n = 1'b1;
            data_n      = hdr;
            par_n       = par ^ bus.src_data ^ hdr;
          end
        end
      end
      S_HEADER: begin
        if (xfer) begin
          state_n = S_PAYLOAD;
          data_n  = rd_data;
          idx_n   = LEN_W'(1);
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          if (idx == len_q) begin
            state_n     = S_PARITY;
            pkt_valid_n = 1'b0;
            data_n      = par;
          end else begin
            data_n = rd_data;
            idx_n  = idx + LEN_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (xfer) begin
          state_n = S_ERRWAIT;
          data_n  = '0;
          timer_n = TW'(ERR_WAIT);
          eacc_n  = 1'b0;
        end
      end
      S_ERRWAIT: begin
        eacc_n  = eacc | bus.err;
        timer_n = timer - TW'(1);
        if (timer == TW'(1)) begin
          state_n   = S_IDLE;
          done_n    = 1'b1;
          pkt_err_n = eacc | bus.err;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      len_q       <= '0;
      dest_q      <= '0;
      par         <= '0;
      timer       <= '0;
      eacc        <= 1'b0;
      src_ready_q <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_q      <= '0;
      tx_active_q <= 1'b0;
      cmd_rej_q   <= 1'b0;
      done_q      <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      len_q       <= len_n;
      dest_q      <= dest_n;
      par         <= par_n;
      timer       <= timer_n;
      eacc        <= eacc_n;
      src_ready_q <= (state_n == S_LOAD);
      pkt_valid_q <= pkt_valid_n;
      data_q      <= data_n;
      tx_active_q <= (state_n != S_IDLE);
      cmd_rej_q   <= cmd_rej_n;
      done_q      <= done_n;
      pkt_err_q   <= pkt_err_n;
    end
  end

  assign bus.src_ready = src_ready_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.data_out  = data_q;
  assign bus.tx_active = tx_active_q;
  assign bus.cmd_rej   = cmd_rej_q;
  assign bus.done      = done_q;
  assign bus.pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: a per-packet wire model
// (header, payload, parity, hold on busy) checked every cycle.
module tb_router_pkt_tx;

  localparam int DATA_W   = 3;
  localparam int LEN_W    = 4;
  localparam int ERR_WAIT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_err = 1'b0;
  logic [DATA_W-1:0] pl [16];

  always #5 clock = ~clock;

  router_pkt_tx_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  router_pkt_tx #(
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .ERR_WAIT (ERR_WAIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic fill_rand(input int l);
    for (int i = 0; i < l; i++) pl[i] = DATA_W'($urandom);
  endtask

  // vmode: 0 valid held, 1 toggling from 0, 2 random
  // bmode: 0 none, 1 random, 2 three cycles on first payload word
  // emode: 0 clean, 1 single pulse, 2 random; abort_p: reset at word p
  task automatic send_pkt(input logic [1:0] d, input int l,
                          input int vmode, input int bmode,
                          input int emode, input int abort_p);
    logic [DATA_W-1:0] w [18];
    logic [DATA_W-1:0] par;
    int acc, k, p, hold, epos;
    logic v, b, e, exp_err;
    w[0] = {1'b0, d};
    par  = w[0];
    for (int i = 0; i < l; i++) begin
      w[i+1] = pl[i];
      par    = par ^ pl[i];
    end
    w[l+1] = par;
    bus.start = 1'b1;
    bus.dest  = d;
    bus.len   = LEN_W'(l);
    bus.src_valid = 1'b0;
    @(negedge clock);
    bus.dest = 2'($urandom);
    bus.len  = LEN_W'($urandom);
    acc = 0;
    k   = 0;
    while (acc < l) begin
      n_cmp++;
      if (bus.src_ready !== 1'b1 || bus.tx_active !== 1'b1 ||
          bus.pkt_valid !== 1'b0 || bus.done !== 1'b0 ||
          bus.cmd_rej !== 1'b0 || bus.pkt_err !== last_err) begin
        n_bad++;
        $display("FAIL load[%0d]: rdy=%b act=%b v=%b done=%b rej=%b perr=%b want 1 1 0 0 0 %b",
                 k, bus.src_ready, bus.tx_active, bus.pkt_valid,
                 bus.done, bus.cmd_rej, bus.pkt_err, last_err);
      end
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? k[0] : 1'($urandom);
      bus.src_valid = v;
      bus.src_data  = v ? pl[acc] : DATA_W'($urandom);
      bus.err   = 1'($urandom);
      bus.start = 1'($urandom);
      bus.busy  = 1'($urandom);
      if (v) acc++;
      k++;
      @(negedge clock);
    end
    bus.src_valid = 1'b0;
    p    = 0;
    hold = 0;
    while (p <= l + 1) begin
      if (p == abort_p) begin
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({bus.pkt_valid, bus.data_out, bus.tx_active, bus.src_ready,
             bus.done, bus.cmd_rej, bus.pkt_err} !== '0) begin
          n_bad++;
          $display("FAIL mid_reset: v=%b d=%b act=%b rdy=%b done=%b rej=%b perr=%b want all 0",
                   bus.pkt_valid, bus.data_out, bus.tx_active,
                   bus.src_ready, bus.done, bus.cmd_rej, bus.pkt_err);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.busy  = 1'b0;
        last_err  = 1'b0;
        return;
      end
      n_cmp++;
      if (bus.pkt_valid !== (p <= l) || bus.data_out !== w[p] ||
          bus.src_ready !== 1'b0 || bus.tx_active !== 1'b1 ||
          bus.done !== 1'b0 || bus.pkt_err !== last_err) begin
        n_bad++;
        $display("FAIL wire[%0d]: v=%b d=%b rdy=%b act=%b done=%b want v=%b d=%b rdy=0 act=1 done=0",
                 p, bus.pkt_valid, bus.data_out, bus.src_ready,
                 bus.tx_active, bus.done, (p <= l), w[p]);
      end
      b = 1'b0;
      if (bmode == 1) b = ($urandom_range(0, 2) == 0);
      if (bmode == 2 && p == 1 && hold < 3) begin
        b = 1'b1;
        hold++;
      end
      bus.busy  = b;
      bus.err   = 1'($urandom);
      bus.start = 1'($urandom);
      if (!b) p++;
      @(negedge clock);
    end
    exp_err = 1'b0;
    epos = $urandom_range(1, ERR_WAIT);
    for (int s = 1; s <= ERR_WAIT; s++) begin
      n_cmp++;
      if (bus.pkt_valid !== 1'b0 || bus.data_out !== '0 ||
          bus.tx_active !== 1'b1 || bus.done !== 1'b0 ||
          bus.pkt_err !== last_err) begin
        n_bad++;
        $display("FAIL errwait[%0d]: v=%b d=%b act=%b done=%b perr=%b want 0 0 1 0 %b",
                 s, bus.pkt_valid, bus.data_out, bus.tx_active,
                 bus.done, bus.pkt_err, last_err);
      end
      e = (emode == 0) ? 1'b0 : (emode == 1) ? (s == epos) : 1'($urandom);
      bus.err   = e;
      exp_err   = exp_err | e;
      bus.start = 1'($urandom);
      bus.busy  = 1'($urandom);
      @(negedge clock);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.pkt_err !== exp_err ||
        bus.tx_active !== 1'b0 || bus.pkt_valid !== 1'b0 ||
        bus.data_out !== '0) begin
      n_bad++;
      $display("FAIL done: done=%b perr=%b act=%b v=%b d=%b want 1 %b 0 0 0",
               bus.done, bus.pkt_err, bus.tx_active, bus.pkt_valid,
               bus.data_out, exp_err);
    end
    last_err  = exp_err;
    bus.start = 1'b0;
    bus.err   = 1'($urandom);
    bus.busy  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({bus.src_ready, bus.pkt_valid, bus.data_out, bus.tx_active,
         bus.cmd_rej, bus.done, bus.pkt_err} !== '0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b v=%b d=%b act=%b rej=%b done=%b perr=%b want all 0",
               bus.src_ready, bus.pkt_valid, bus.data_out, bus.tx_active,
               bus.cmd_rej, bus.done, bus.pkt_err);
    end
    reset = 1'b0;
    last_err = 1'b0;
  endtask

  task automatic test_basic();
    pl[0] = 3'b101;
    pl[1] = 3'b011;
    send_pkt(2'd1, 2, 0, 0, 0, -1);
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    pl[0] = 3'b101;
    pl[1] = 3'b011;
    send_pkt(2'd1, 2, 0, 2, 0, -1);
    @(negedge clock);
  endtask

  task automatic test_cmd_rej();
    logic [1:0] ds [3];
    int ls [3];
    ds = '{2'd3, 2'd1, 2'd3};
    ls = '{5, 0, 0};
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      bus.dest  = ds[i];
      bus.len   = LEN_W'(ls[i]);
      @(negedge clock);
      bus.start = 1'b0;
      n_cmp++;
      if (bus.cmd_rej !== 1'b1 || bus.tx_active !== 1'b0 ||
          bus.src_ready !== 1'b0 || bus.pkt_err !== last_err) begin
        n_bad++;
        $display("FAIL rej[%0d]: rej=%b act=%b rdy=%b want 1 0 0",
                 i, bus.cmd_rej, bus.tx_active, bus.src_ready);
      end
      @(negedge clock);
      n_cmp++;
      if (bus.cmd_rej !== 1'b0 || bus.tx_active !== 1'b0 ||
          bus.src_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL rej_end[%0d]: rej=%b act=%b rdy=%b want 0 0 0",
                 i, bus.cmd_rej, bus.tx_active, bus.src_ready);
      end
    end
  endtask

  task automatic test_long();
    fill_rand(15);
    send_pkt(2'd2, 15, 1, 0, 0, -1);
    @(negedge clock);
  endtask

  task automatic test_err();
    fill_rand(3);
    send_pkt(2'd0, 3, 0, 0, 1, -1);
    fill_rand(4);
    send_pkt(2'd2, 4, 0, 0, 0, -1);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int l;
    for (int i = 0; i < 12; i++) begin
      l = $urandom_range(1, 15);
      fill_rand(l);
      send_pkt(2'($urandom_range(0, 2)), l, 2, 1, 2, -1);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    fill_rand(4);
    send_pkt(2'd1, 4, 0, 0, 0, 2);
    fill_rand(3);
    send_pkt(2'd0, 3, 0, 1, 0, -1);
    @(negedge clock);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.dest      = '0;
    bus.len       = '0;
    bus.src_data  = '0;
    bus.src_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.err       = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_cmd_rej();
    test_long();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the router's input port. It accepts a transmit command (destination, payload length) and the payload words from an upstream source, and buffers the whole payload. It then drives the router ingress with a header word, the payload words and a trailing parity word, honouring the router's `busy` back-pressure. After each packet it samples the router's `err` status and reports completion upstream.

## Interface
Parameters:
- `DATA_W`, 3: width of a word on the wire.
- `LEN_W`, 4: width of the length field. Maximum payload is 2^LEN_W−1 words.
- `ERR_WAIT`, 2: number of cycles after parity acceptance during which router `err` is sampled. Legal range is ≥1.

Ports:
- `clock` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command strobe. Sampled only in IDLE.
- `dest` in 2: destination port. 0..2 are legal; 3 is illegal.
- `len` in LEN_W: payload word count. 0 is illegal.
- `src_data` in DATA_W: payload word from upstream.
- `src_valid` in 1: upstream word valid.
- `src_ready` out 1: block accepts a payload word.
- `busy` in 1: router back-pressure.
- `err` in 1: router parity-error flag.
- `pkt_valid` out 1: drives the router `pkt_valid`.
- `data_out` out DATA_W: drives the router `data_in`.
- `tx_active` out 1: high whenever state ≠ IDLE.
- `cmd_rej` out 1: one-cycle pulse when an illegal command is seen.
- `done` out 1: one-cycle pulse when a packet completes.
- `pkt_err` out 1: error result of the last packet. Valid with `done` and held until the next `done`.

## Operation
- All outputs are registered. Reset values are 0 for every output.
- State machine: IDLE → LOAD → HEADER → PAYLOAD → PARITY → ERRWAIT → IDLE.
- IDLE:
  - `start` with legal `dest`/`len`: latch them, clear the word counter, clear the parity accumulator, go to LOAD.
  - `start` with illegal `dest` or `len`: pulse `cmd_rej` and stay in IDLE.
- LOAD:
  - `src_ready`=1.
  - Each `src_valid`&`src_ready` writes `buf[cnt]`, XORs the word into parity, and increments `cnt`.
  - On the write of word `len`−1: go to HEADER. Load `pkt_valid`=1 and `data_out`={1'b0,dest} in the same edge. XOR the header into parity.
- Transfer rule: the word on `data_out` is consumed at a rising edge where `busy`=0. While `busy`=1, `data_out` and `pkt_valid` hold unchanged.
- HEADER: on transfer, go to PAYLOAD, drive `buf[0]`, set `idx`=1.
- PAYLOAD, on transfer:
  - If `idx`==`len`: go to PARITY, drive `pkt_valid`=0 and `data_out`=parity.
  - Otherwise: drive `buf[idx]` and increment `idx`.
- PARITY: on transfer, go to ERRWAIT, drive `data_out`=0, load the timer with ERR_WAIT.
- ERRWAIT:
  - Each cycle, OR `err` into the accumulated error and decrement the timer.
  - At expiry: go to IDLE, pulse `done`, update `pkt_err`.
- Parity word = XOR of the header and all payload words.
- `start` outside IDLE is ignored.
- `src_ready` is 0 outside LOAD.
- `reset` mid-packet: next cycle the block is in IDLE with all outputs 0. Buffer contents are don't-care. No parity word is emitted.
- `err` outside ERRWAIT is ignored.

## Timing
- `start` in cycle 0 → LOAD from cycle 1.
- With `src_valid` held high, payload words are taken in cycles 1..len. The header appears on `data_out` in cycle len+1.
- With `busy`=0 throughout, the wire carries header, len payload words and parity in len+2 consecutive cycles. `pkt_valid` is high for len+1 of them.
- Each `busy`=1 cycle adds exactly one cycle of hold.
- `done` fires ERR_WAIT cycles after the parity-transfer edge.
- IDLE accepts a new `start` in the same cycle `done` is high.
- `cmd_rej` is asserted the cycle after the offending `start`.

## Structure
- Package `router_tx_pkg`:
  - state enum
  - `DATA_W`/`LEN_W` defaults
  - `HDR_RSVD` constant (1'b0)
  - `make_header(dest)` function
  - `DEST_ILLEGAL` constant (2'd3)
- Sub-module `router_tx_buf`: 2^LEN_W × DATA_W payload store with a synchronous write port and an asynchronous read port (write enable, write address, read address).
- Top `router_pkt_tx`: FSM, counters, parity accumulator, output registers.

## Test plan
- dest=1, len=2, payload 101, 011, `busy`=0 → wire shows 001(v=1), 101(v=1), 011(v=1), 111(v=0); `done` fires with `pkt_err`=0.
- Same packet with `busy`=1 for 3 cycles during the first payload word → 101 held 4 cycles, sequence otherwise identical, `done` 3 cycles later.
- `start` with dest=3 or len=0 → `cmd_rej` pulses once, `tx_active` stays 0, `src_ready` stays 0.
- len=15 with `src_valid` toggling every cycle → 15 words accepted over 30 cycles, then 17-word transfer, parity correct.
- `err`=1 for one cycle inside ERRWAIT → `pkt_err`=1 with `done`. Next clean packet → `pkt_err`=0.
- `reset` asserted during PAYLOAD → next cycle `pkt_valid`=0, `data_out`=0, `tx_active`=0. A subsequent packet transmits correctly.
